vx_dcache_lane_buffer: RTL and testbench

Per-lane elastic buffer between the core's data-cache request port and the data cache, one instance per `DCACHE_NUM_REQS` lane. Decouples core and cache with a 2-entry request queue and a registered response slot, and caps outstanding reads with a credit counter. An optional compiled-in monitor accumulates read and write counts and pending-read latency, matching the core's load-latency accounting.

---
 rtl/vx_dcache_lane_buffer_pkg.sv | 29 ++
 rtl/vx_dcache_lane_buffer_fifo2.sv | 66 ++++++
 rtl/vx_dcache_lane_buffer.sv | 158 +++++++++++++++
 tb/tb_vx_dcache_lane_buffer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/vx_dcache_lane_buffer_pkg.sv
// VX_gpu_pkg: shared types for the dcache lane buffer.
// Perf monitor width applies when VX_DCACHE_LANE_PERF_EN is defined.
package VX_gpu_pkg;

    localparam int DCACHE_LANE_ADDR_W = 30;
    localparam int DCACHE_LANE_DATA_W = 32;
    localparam int DCACHE_LANE_TAG_W  = 8;
    localparam int DCACHE_LANE_PERF_W = 44;

    typedef struct packed {
        logic                                rw;
        logic [DCACHE_LANE_ADDR_W-1:0]       addr;
        logic [DCACHE_LANE_DATA_W/8-1:0]     byteen;
        logic [DCACHE_LANE_DATA_W-1:0]       data;
        logic [DCACHE_LANE_TAG_W-1:0]        tag;
    } dcache_lane_req_t;

    typedef struct packed {
        logic [DCACHE_LANE_DATA_W-1:0] data;
        logic [DCACHE_LANE_TAG_W-1:0]  tag;
    } dcache_lane_rsp_t;

    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_FULL  = 2'd2
    } lane_q_state_e;

endpackage

// File: rtl/vx_dcache_lane_buffer_fifo2.sv
// vx_lane_req_fifo2: 2-entry request queue with full/empty flags.
// Occupancy is tracked by an EMPTY/ONE/FULL state machine.
module vx_lane_req_fifo2
    import VX_gpu_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty
);

    lane_q_state_e r_state;
    lane_q_state_e w_state_nxt;
    logic          r_wptr;
    logic          r_rptr;
    logic [DW-1:0] r_mem [2];
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_state == Q_FULL);
    assign o_empty = (r_state == Q_EMPTY);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = r_mem[r_rptr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= Q_EMPTY;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) r_wptr <= ~r_wptr;
            if (w_pop)  r_rptr <= ~r_rptr;
        end
    end

    // Storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            Q_EMPTY: begin
                if (w_push) w_state_nxt = Q_ONE;
            end
            Q_ONE: begin
                if (w_push && !w_pop)      w_state_nxt = Q_FULL;
                else if (!w_push && w_pop) w_state_nxt = Q_EMPTY;
            end
            Q_FULL: begin
                if (w_pop) w_state_nxt = Q_ONE;
            end
            default: w_state_nxt = Q_EMPTY;
        endcase
    end

endmodule

// File: rtl/vx_dcache_lane_buffer.sv
// vx_dcache_lane_buffer: per-lane request queue, read credit cap, response slot.
// Define VX_DCACHE_LANE_PERF_EN for perf counters and the underflow assertion.
module vx_dcache_lane_buffer
    import VX_gpu_pkg::*;
#(
    parameter int ADDR_WIDTH    = DCACHE_LANE_ADDR_W,
    parameter int DATA_WIDTH    = DCACHE_LANE_DATA_W,
    parameter int TAG_WIDTH     = DCACHE_LANE_TAG_W,
    parameter int MAX_PENDING   = 4,
    localparam int BYTEEN_WIDTH = DATA_WIDTH / 8,
    localparam int PCNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    core_req_valid,
    output logic                    core_req_ready,
    input  logic                    core_req_rw,
    input  logic [ADDR_WIDTH-1:0]   core_req_addr,
    input  logic [BYTEEN_WIDTH-1:0] core_req_byteen,
    input  logic [DATA_WIDTH-1:0]   core_req_data,
    input  logic [TAG_WIDTH-1:0]    core_req_tag,
    output logic                    core_rsp_valid,
    input  logic                    core_rsp_ready,
    output logic [DATA_WIDTH-1:0]   core_rsp_data,
    output logic [TAG_WIDTH-1:0]    core_rsp_tag,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_rw,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic [BYTEEN_WIDTH-1:0] mem_req_byteen,
    output logic [DATA_WIDTH-1:0]   mem_req_data,
    output logic [TAG_WIDTH-1:0]    mem_req_tag,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
    input  logic [TAG_WIDTH-1:0]    mem_rsp_tag,
    output logic                    mem_rsp_ready,
    output logic [PCNT_W-1:0]       pending_count
`ifdef VX_DCACHE_LANE_PERF_EN
    ,
    output logic [DCACHE_LANE_PERF_W-1:0] perf_reads,
    output logic [DCACHE_LANE_PERF_W-1:0] perf_writes,
    output logic [DCACHE_LANE_PERF_W-1:0] perf_read_lat
`endif
);

    localparam int REQ_W = 1 + ADDR_WIDTH + BYTEEN_WIDTH + DATA_WIDTH + TAG_WIDTH;
    localparam logic [PCNT_W-1:0] P_MAX = PCNT_W'(MAX_PENDING);
    localparam logic [PCNT_W-1:0] P_ONE = PCNT_W'(1);

    logic [REQ_W-1:0]      w_push_data;
    logic [REQ_W-1:0]      w_head;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_credit_ok;
    logic                  w_rd_fire;
    logic                  w_rsp_fire;
    logic                  w_crsp_fire;
    logic [PCNT_W-1:0]     r_pend;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic [TAG_WIDTH-1:0]  r_rsp_tag;

    assign w_push_data = {core_req_rw, core_req_addr, core_req_byteen,
                          core_req_data, core_req_tag};
    assign core_req_ready = ~w_full;
    assign w_push         = core_req_valid & ~w_full;

    vx_lane_req_fifo2 #(
        .DW (REQ_W)
    ) u_req_fifo (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_data),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign {mem_req_rw, mem_req_addr, mem_req_byteen,
            mem_req_data, mem_req_tag} = w_head;

    // A blocked read head also holds back writes queued behind it.
    assign w_credit_ok   = (r_pend < P_MAX);
    assign mem_req_valid = ~w_empty & (mem_req_rw | w_credit_ok);
    assign w_pop         = mem_req_valid & mem_req_ready;
    assign w_rd_fire     = w_pop & ~mem_req_rw;

    assign mem_rsp_ready = ~r_rsp_valid | core_rsp_ready;
    assign w_rsp_fire    = mem_rsp_valid & mem_rsp_ready;
    assign w_crsp_fire   = r_rsp_valid & core_rsp_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= '0;
        end else if (w_rd_fire && !w_rsp_fire) begin
            r_pend <= r_pend + P_ONE;
        end else if (!w_rd_fire && w_rsp_fire && r_pend != '0) begin
            r_pend <= r_pend - P_ONE;
        end
    end

    assign pending_count = r_pend;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_valid <= 1'b0;
        end else if (w_rsp_fire) begin
            r_rsp_valid <= 1'b1;
        end else if (w_crsp_fire) begin
            r_rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rsp_fire) begin
            r_rsp_data <= mem_rsp_data;
            r_rsp_tag  <= mem_rsp_tag;
        end
    end

    assign core_rsp_valid = r_rsp_valid;
    assign core_rsp_data  = r_rsp_data;
    assign core_rsp_tag   = r_rsp_tag;

`ifdef VX_DCACHE_LANE_PERF_EN
    localparam int PERF_W = DCACHE_LANE_PERF_W;
    localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

    logic [PERF_W-1:0] r_perf_reads;
    logic [PERF_W-1:0] r_perf_writes;
    logic [PERF_W-1:0] r_perf_lat;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_reads  <= '0;
            r_perf_writes <= '0;
            r_perf_lat    <= '0;
        end else begin
            if (w_rd_fire)              r_perf_reads  <= r_perf_reads + PERF_ONE;
            if (w_pop && mem_req_rw)    r_perf_writes <= r_perf_writes + PERF_ONE;
            r_perf_lat <= r_perf_lat + PERF_W'(r_pend);
        end
    end

    assign perf_reads    = r_perf_reads;
    assign perf_writes   = r_perf_writes;
    assign perf_read_lat = r_perf_lat;

    a_no_underflow: assert property (
        @(posedge clk) disable iff (!reset) !(w_rsp_fire && r_pend == '0)
    );
`endif

endmodule

// File: tb/tb_vx_dcache_lane_buffer.sv
// tb_vx_dcache_lane_buffer: directed scenarios plus random traffic
// checked each cycle against a queue-based reference model.
module tb_vx_dcache_lane_buffer;
    import VX_gpu_pkg::*;

    localparam int MAXP = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        core_req_valid, core_req_ready, core_req_rw;
    logic [29:0] core_req_addr;
    logic [3:0]  core_req_byteen;
    logic [31:0] core_req_data;
    logic [7:0]  core_req_tag;
    logic        core_rsp_valid, core_rsp_ready;
    logic [31:0] core_rsp_data;
    logic [7:0]  core_rsp_tag;
    logic        mem_req_valid, mem_req_ready, mem_req_rw;
    logic [29:0] mem_req_addr;
    logic [3:0]  mem_req_byteen;
    logic [31:0] mem_req_data;
    logic [7:0]  mem_req_tag;
    logic        mem_rsp_valid, mem_rsp_ready;
    logic [31:0] mem_rsp_data;
    logic [7:0]  mem_rsp_tag;
    logic [2:0]  pending_count;
`ifdef VX_DCACHE_LANE_PERF_EN
    logic [43:0] perf_reads, perf_writes, perf_read_lat;
`endif

    always #5 clk = ~clk;

    vx_dcache_lane_buffer #(.MAX_PENDING(MAXP)) dut (
        .clk             (clk),
        .reset           (reset),
        .core_req_valid  (core_req_valid),
        .core_req_ready  (core_req_ready),
        .core_req_rw     (core_req_rw),
        .core_req_addr   (core_req_addr),
        .core_req_byteen (core_req_byteen),
        .core_req_data   (core_req_data),
        .core_req_tag    (core_req_tag),
        .core_rsp_valid  (core_rsp_valid),
        .core_rsp_ready  (core_rsp_ready),
        .core_rsp_data   (core_rsp_data),
        .core_rsp_tag    (core_rsp_tag),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_rw      (mem_req_rw),
        .mem_req_addr    (mem_req_addr),
        .mem_req_byteen  (mem_req_byteen),
        .mem_req_data    (mem_req_data),
        .mem_req_tag     (mem_req_tag),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_data    (mem_rsp_data),
        .mem_rsp_tag     (mem_rsp_tag),
        .mem_rsp_ready   (mem_rsp_ready),
        .pending_count   (pending_count)
`ifdef VX_DCACHE_LANE_PERF_EN
        ,
        .perf_reads      (perf_reads),
        .perf_writes     (perf_writes),
        .perf_read_lat   (perf_read_lat)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    dcache_lane_req_t q[$];
    int          pend;
    bit          slot_v;
    logic [39:0] slot;
    int          n_rd, n_wr, n_push;
    longint      lat;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, check at negedge+1, advance model, wait posedge.
    task automatic step(input bit crv, input bit rw, input bit mrv,
                        input bit mrr, input bit crr);
        dcache_lane_req_t req;
        dcache_lane_req_t head;
        bit exp_rdy, exp_mv, mfire, pushf, rspf;
        int pend0;
        @(negedge clk);
        req.rw     = rw;
        req.addr   = 30'($urandom);
        req.byteen = 4'($urandom);
        req.data   = $urandom;
        req.tag    = 8'($urandom);
        core_req_valid = crv;
        {core_req_rw, core_req_addr, core_req_byteen,
         core_req_data, core_req_tag} = req;
        mem_req_ready  = mrr;
        mem_rsp_valid  = mrv;
        mem_rsp_data   = $urandom;
        mem_rsp_tag    = 8'($urandom);
        core_rsp_ready = crr;
        #1;
        exp_rdy = (q.size() < 2);
        exp_mv  = (q.size() > 0) && (q[0].rw || pend < MAXP);
        chk("core_req_ready", core_req_ready, exp_rdy);
        chk("mem_req_valid", mem_req_valid, exp_mv);
        if (exp_mv)
            chk("mem_req_payload", {mem_req_rw, mem_req_addr, mem_req_byteen,
                                    mem_req_data, mem_req_tag}, q[0]);
        chk("mem_rsp_ready", mem_rsp_ready, !slot_v || crr);
        chk("core_rsp_valid", core_rsp_valid, slot_v);
        if (slot_v)
            chk("core_rsp_payload", {core_rsp_data, core_rsp_tag}, slot);
        chk("pending_count", pending_count, pend);
`ifdef VX_DCACHE_LANE_PERF_EN
        chk("perf_reads", perf_reads, n_rd);
        chk("perf_writes", perf_writes, n_wr);
        chk("perf_read_lat", perf_read_lat, lat);
`endif
        pend0 = pend;
        mfire = exp_mv && mrr;
        pushf = crv && exp_rdy;
        rspf  = mrv && (!slot_v || crr);
        if (mfire) begin
            head = q.pop_front();
            if (head.rw) n_wr++;
            else begin
                n_rd++;
                pend++;
            end
        end
        if (rspf) begin
            if (pend > 0) pend--;
            slot   = {mem_rsp_data, mem_rsp_tag};
            slot_v = 1'b1;
        end else if (slot_v && crr) begin
            slot_v = 1'b0;
        end
        if (pushf) begin
            q.push_back(req);
            n_push++;
        end
        lat += pend0;
        @(posedge clk);
    endtask

    task automatic hard_reset();
        #2;
        core_req_valid = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_req_ready  = 1'b0;
        core_rsp_ready = 1'b1;
        reset = 1'b0;
        #1;
        chk("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk("rst_core_rsp_valid", core_rsp_valid, 1'b0);
        chk("rst_pending", pending_count, 3'd0);
        chk("rst_core_req_ready", core_req_ready, 1'b1);
        chk("rst_mem_rsp_ready", mem_rsp_ready, 1'b1);
`ifdef VX_DCACHE_LANE_PERF_EN
        chk("rst_perf_reads", perf_reads, 44'd0);
        chk("rst_perf_writes", perf_writes, 44'd0);
        chk("rst_perf_lat", perf_read_lat, 44'd0);
`endif
        q.delete();
        pend   = 0;
        slot_v = 1'b0;
        lat    = 0;
        n_rd   = 0;
        n_wr   = 0;
        n_push = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        hard_reset();

        // Credit cap: six reads, no responses.
        repeat (12) step(n_push < 6, 1'b0, 1'b0, 1'b1, 1'b1);
        #2;
        chk("cap_pending", pending_count, 3'd4);
        chk("cap_mem_req_valid", mem_req_valid, 1'b0);
        chk("cap_core_req_ready", core_req_ready, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        #2;
        chk("cap_refill_pending", pending_count, 3'd4);

        // Build 2 queued + 1 held, then reset mid-stream.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("pre_rst_core_rsp_valid", core_rsp_valid, 1'b1);
        chk("pre_rst_full", core_req_ready, 1'b0);
        hard_reset();

        // Write at the head bypasses an exhausted credit.
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        #2;
        chk("wr_cap_pending", pending_count, 3'd4);
        chk("wr_cap_drained", mem_req_valid, 1'b0);

        // Read fire and response in the same cycle at count 2.
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        #2;
        chk("simul_pending", pending_count, 3'd2);

        hard_reset();
        repeat (3000)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                 pend > 0 && $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
